// File: rtl/fab_clk_gen_pkg.sv
// Shared types and sizing helpers for the fabric clock-enable generator.
// ch_cfg_t is sized by CFG_W; the top-level DIV_W must equal CFG_W.
package fab_clk_gen_pkg;

    localparam int unsigned CFG_W           = 8;
    localparam int unsigned RST_DIV_DEF     = 3;
    localparam int unsigned LOCK_CYCLES_DEF = 16;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] phase;
    } ch_cfg_t;

    function automatic int unsigned ch_idx_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Wide enough to hold LOCK_CYCLES itself so the counter can saturate on it.
    function automatic int unsigned lock_cnt_w(input int unsigned lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/fab_clk_gen_ch.sv
// One divider channel: period counter, registered CE/Y, boundary-aligned config
// apply and a saturating lock counter.
module fab_clk_gen_ch
    import fab_clk_gen_pkg::*;
#(
    parameter int unsigned RST_DIV     = RST_DIV_DEF,
    parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    en_i,
    input  logic    apply_i,
    input  ch_cfg_t cfg_i,
    input  logic    lock_hold_i,
    output logic    boundary_o,
    output logic    ce_o,
    output logic    y_o,
    output logic    lock_o
);

    localparam int unsigned LockCntW = lock_cnt_w(LOCK_CYCLES);
    localparam logic [CFG_W-1:0]    RstDiv  = CFG_W'(RST_DIV);
    localparam logic [LockCntW-1:0] LockMax = LockCntW'(LOCK_CYCLES);

    logic [CFG_W-1:0]    div_q, div_d;
    logic [CFG_W-1:0]    phase_q, phase_d;
    logic [CFG_W-1:0]    cnt_q, cnt_d;
    logic                ce_q, ce_d;
    logic                y_q, y_d;
    logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;
    logic                lock_q, lock_d;

    // A stopped channel is always at a safe point to take new settings.
    assign boundary_o = !en_i || (cnt_q == div_q);

    always_comb begin
        div_d      = div_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        lock_cnt_d = lock_cnt_q;

        if (apply_i) begin
            div_d   = cfg_i.div;
            phase_d = (cfg_i.phase > cfg_i.div) ? cfg_i.div : cfg_i.phase;
        end

        if (apply_i || !en_i) begin
            cnt_d = phase_d;
        end else if (cnt_q == div_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are registered from the next count so they line up with cnt_q.
        ce_d = en_i && (cnt_d == div_d);
        y_d  = en_i && (div_d != '0) && (cnt_d <= (div_d >> 1));

        if (lock_hold_i) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LockMax) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
        lock_d = (lock_cnt_d == LockMax);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q      <= RstDiv;
            phase_q    <= '0;
            cnt_q      <= '0;
            ce_q       <= 1'b0;
            y_q        <= 1'b0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            ce_q       <= ce_d;
            y_q        <= y_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign ce_o   = ce_q;
    assign y_o    = y_q;
    assign lock_o = lock_q;

endmodule

// File: rtl/fab_clk_gen.sv
// Multi-channel programmable clock-enable generator: single pending config slot
// with valid/ready handshake, per-channel dividers and a registered global LOCK.
module fab_clk_gen
    import fab_clk_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned DIV_W       = CFG_W,
    parameter int unsigned RST_DIV     = RST_DIV_DEF,
    parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF,
    localparam int unsigned CH_W       = ch_idx_w(NUM_CH)
) (
    input  logic              FAB_CLK,
    input  logic              RESET,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [DIV_W-1:0]  CFG_DIV,
    input  logic [DIV_W-1:0]  CFG_PHASE,
    input  logic [NUM_CH-1:0] CH_EN,
    output logic [NUM_CH-1:0] CE,
    output logic [NUM_CH-1:0] Y,
    output logic [NUM_CH-1:0] CH_LOCK,
    output logic              LOCK
);

    localparam logic [CH_W:0] NumChW = (CH_W + 1)'(NUM_CH);

    logic              pend_valid_q, pend_valid_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    ch_cfg_t           pend_cfg_q, pend_cfg_d;
    logic              ready_q, ready_d;
    logic              lock_all_q, lock_all_d;

    logic              accept;
    logic              in_range;
    logic [NUM_CH-1:0] boundary;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] lock_hold;

    assign accept   = CFG_VALID && ready_q;
    assign in_range = ({1'b0, CFG_CH} < NumChW);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign apply[i]     = pend_valid_q && (pend_ch_q == CH_W'(i)) && boundary[i];
        // Lock restarts on accept and stays cleared until the apply edge.
        assign lock_hold[i] = (accept && in_range && (CFG_CH == CH_W'(i)))
                           || (pend_valid_q && (pend_ch_q == CH_W'(i)));

        fab_clk_gen_ch #(
            .RST_DIV     (RST_DIV),
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_ch (
            .clk_i       (FAB_CLK),
            .rst_i       (RESET),
            .en_i        (CH_EN[i]),
            .apply_i     (apply[i]),
            .cfg_i       (pend_cfg_q),
            .lock_hold_i (lock_hold[i]),
            .boundary_o  (boundary[i]),
            .ce_o        (CE[i]),
            .y_o         (Y[i]),
            .lock_o      (CH_LOCK[i])
        );
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_ch_d    = pend_ch_q;
        pend_cfg_d   = pend_cfg_q;

        if (|apply) begin
            pend_valid_d = 1'b0;
        end
        // Out-of-range targets complete the handshake but leave no trace.
        if (accept && in_range) begin
            pend_valid_d     = 1'b1;
            pend_ch_d        = CFG_CH;
            pend_cfg_d.div   = CFG_DIV;
            pend_cfg_d.phase = CFG_PHASE;
        end

        ready_d    = !pend_valid_d;
        lock_all_d = &CH_LOCK;
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            pend_valid_q <= 1'b0;
            pend_ch_q    <= '0;
            pend_cfg_q   <= '0;
            ready_q      <= 1'b0;
            lock_all_q   <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_ch_q    <= pend_ch_d;
            pend_cfg_q   <= pend_cfg_d;
            ready_q      <= ready_d;
            lock_all_q   <= lock_all_d;
        end
    end

    assign CFG_READY = ready_q;
    assign LOCK      = lock_all_q;

endmodule

// File: tb/tb_fab_clk_gen.sv
// Directed bench for fab_clk_gen; cycle 0 is the first cycle with RESET low and
// all outputs are sampled on the falling edge.
module tb_fab_clk_gen;

    logic       FAB_CLK = 1'b0;
    logic       RESET;
    logic       CFG_VALID;
    logic       CFG_READY;
    logic [1:0] CFG_CH;
    logic [7:0] CFG_DIV;
    logic [7:0] CFG_PHASE;
    logic [2:0] CH_EN;
    logic [2:0] CE;
    logic [2:0] Y;
    logic [2:0] CH_LOCK;
    logic       LOCK;

    int cyc;
    int n_assert;
    int n_fail;

    fab_clk_gen #(
        .NUM_CH      (3),
        .DIV_W       (8),
        .RST_DIV     (3),
        .LOCK_CYCLES (16)
    ) dut (
        .FAB_CLK   (FAB_CLK),
        .RESET     (RESET),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_CH    (CFG_CH),
        .CFG_DIV   (CFG_DIV),
        .CFG_PHASE (CFG_PHASE),
        .CH_EN     (CH_EN),
        .CE        (CE),
        .Y         (Y),
        .CH_LOCK   (CH_LOCK),
        .LOCK      (LOCK)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic go(input int c);
        while (cyc < c) begin
            @(negedge FAB_CLK);
            cyc++;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cfg(input logic v, input logic [1:0] ch, input logic [7:0] d,
                       input logic [7:0] p);
        CFG_VALID = v;
        CFG_CH    = ch;
        CFG_DIV   = d;
        CFG_PHASE = p;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        RESET    = 1'b1;
        CH_EN    = 3'b111;
        cfg(1'b0, 2'd0, 8'd0, 8'd0);
        repeat (3) @(negedge FAB_CLK);
        RESET = 1'b0;

        // Reset defaults: /4, phase 0, CE at 3,7,11, lock at 16, LOCK at 17.
        check("rst_ce", 8'(CE), 8'h0);
        check("rst_y", 8'(Y), 8'h0);
        check("rst_chlock", 8'(CH_LOCK), 8'h0);
        check("rst_lock", 8'(LOCK), 8'h0);
        check("rst_ready", 8'(CFG_READY), 8'h0);
        go(1);  check("ready_up", 8'(CFG_READY), 8'h1);
                check("y_c1", 8'(Y), 8'h7);
        go(2);  check("y_c2", 8'(Y), 8'h0);
        go(3);  check("ce_c3", 8'(CE), 8'h7);
        go(4);  check("ce_c4", 8'(CE), 8'h0);
                check("y_c4", 8'(Y), 8'h7);
        go(7);  check("ce_c7", 8'(CE), 8'h7);
        go(11); check("ce_c11", 8'(CE), 8'h7);
        go(15); check("chlock_c15", 8'(CH_LOCK), 8'h0);
        go(16); check("chlock_c16", 8'(CH_LOCK), 8'h7);
                check("lock_c16", 8'(LOCK), 8'h0);
        go(17); check("lock_c17", 8'(LOCK), 8'h1);

        // ch1 -> div 4 phase 2, accepted while ch1 cnt==1, applied at cnt==3.
        go(21); cfg(1'b1, 2'd1, 8'd4, 8'd2);
                check("ch1_ready_acc", 8'(CFG_READY), 8'h1);
        go(22); cfg(1'b0, 2'd0, 8'd0, 8'd0);
                check("ch1_ready_pend", 8'(CFG_READY), 8'h0);
                check("ch1_lock_clr", 8'(CH_LOCK), 8'h5);
        go(23); check("ch1_ce_apply", 8'(CE), 8'h7);
                check("ch1_ready_apply", 8'(CFG_READY), 8'h0);
                check("ch1_glock", 8'(LOCK), 8'h0);
        go(24); check("ch1_ready_back", 8'(CFG_READY), 8'h1);
                check("ch1_y_c24", 8'(Y), 8'h7);
                check("ch1_ce_c24", 8'(CE), 8'h0);
        go(25); check("ch1_y_c25", 8'(Y), 8'h5);
        go(26); check("ch1_ce_c26", 8'(CE), 8'h2);
                check("ch1_y_c26", 8'(Y), 8'h0);
        go(27); check("ch1_ce_c27", 8'(CE), 8'h5);
                check("ch1_y_c27", 8'(Y), 8'h2);
        go(31); check("ch1_ce_c31", 8'(CE), 8'h7);
        go(36); check("ch1_ce_c36", 8'(CE), 8'h2);
        go(39); check("ch1_lock_c39", 8'(CH_LOCK), 8'h5);
        go(40); check("ch1_lock_c40", 8'(CH_LOCK), 8'h7);
        go(41); check("ch1_glock_c41", 8'(LOCK), 8'h1);

        // ch0: VALID held across a pending request; the second waits for READY.
        go(44); cfg(1'b1, 2'd0, 8'd5, 8'd1);
                check("ch0_ready_a", 8'(CFG_READY), 8'h1);
        go(45); cfg(1'b1, 2'd0, 8'd2, 8'd0);
                check("ch0_ready_pend", 8'(CFG_READY), 8'h0);
        go(47); check("ch0_ce_c47", 8'(CE[0]), 8'h1);
                check("ch0_ready_c47", 8'(CFG_READY), 8'h0);
        go(48); check("ch0_ready_b", 8'(CFG_READY), 8'h1);
                check("ch0_y_c48", 8'(Y[0]), 8'h1);
        go(49); cfg(1'b0, 2'd0, 8'd0, 8'd0);
                check("ch0_ready_c49", 8'(CFG_READY), 8'h0);
        go(50); check("ch0_ce_c50", 8'(CE[0]), 8'h0);
                check("ch0_y_c50", 8'(Y[0]), 8'h0);
        go(52); check("ch0_ce_c52", 8'(CE[0]), 8'h1);
                check("ch0_ready_c52", 8'(CFG_READY), 8'h0);
        go(53); check("ch0_ready_c53", 8'(CFG_READY), 8'h1);
                check("ch0_y_c53", 8'(Y[0]), 8'h1);
        go(55); check("ch0_ce_c55", 8'(CE[0]), 8'h1);
        go(56); check("ch0_ce_c56", 8'(CE[0]), 8'h0);
        go(58); check("ch0_ce_c58", 8'(CE[0]), 8'h1);

        // ch2 stopped, div 0 phase 7: phase clamps to 0, applied on the next edge.
        go(59); CH_EN = 3'b011;
        go(60); cfg(1'b1, 2'd2, 8'd0, 8'd7);
                check("ch2_ce_off", 8'(CE[2]), 8'h0);
                check("ch2_y_off", 8'(Y[2]), 8'h0);
                check("ch2_ready_acc", 8'(CFG_READY), 8'h1);
        go(61); cfg(1'b0, 2'd0, 8'd0, 8'd0);
                check("ch2_ready_pend", 8'(CFG_READY), 8'h0);
        go(62); check("ch2_ready_back", 8'(CFG_READY), 8'h1);
                check("ch2_lock_clr", 8'(CH_LOCK[2]), 8'h0);
        go(64); CH_EN = 3'b111;
                check("ch2_ce_c64", 8'(CE[2]), 8'h0);
        go(65); check("ch2_ce_c65", 8'(CE[2]), 8'h1);
                check("ch2_y_c65", 8'(Y[2]), 8'h0);
        go(66); check("ch2_ce_c66", 8'(CE[2]), 8'h1);
        go(67); check("ch2_ce_c67", 8'(CE[2]), 8'h1);
                check("ch2_y_c67", 8'(Y[2]), 8'h0);

        // CFG_CH is 2 bits wide, so 3 is the out-of-range index.
        go(70); cfg(1'b1, 2'd3, 8'd9, 8'd1);
                check("oor_ready_acc", 8'(CFG_READY), 8'h1);
                check("oor_ce0_c70", 8'(CE[0]), 8'h1);
        go(71); cfg(1'b0, 2'd0, 8'd0, 8'd0);
                check("oor_ready_c71", 8'(CFG_READY), 8'h1);
                check("oor_chlock_c71", 8'(CH_LOCK), 8'h3);
        go(73); check("oor_ce_c73", 8'(CE), 8'h5);
        go(77); check("ch2_lock_c77", 8'(CH_LOCK), 8'h3);
        go(78); check("ch2_lock_c78", 8'(CH_LOCK), 8'h7);
                check("glock_c78", 8'(LOCK), 8'h0);
        go(79); check("glock_c79", 8'(LOCK), 8'h1);

        // One-cycle reset while a ch1 config is pending and all channels locked.
        go(86); cfg(1'b1, 2'd1, 8'd7, 8'd0);
                check("rp_ce1_c86", 8'(CE[1]), 8'h1);
                check("rp_ready_c86", 8'(CFG_READY), 8'h1);
        go(87); cfg(1'b0, 2'd0, 8'd0, 8'd0);
                RESET = 1'b1;
                check("rp_ready_c87", 8'(CFG_READY), 8'h0);
                check("rp_chlock_c87", 8'(CH_LOCK), 8'h5);
                check("rp_glock_c87", 8'(LOCK), 8'h1);
        go(88); RESET = 1'b0;
                check("rp_ce", 8'(CE), 8'h0);
                check("rp_y", 8'(Y), 8'h0);
                check("rp_chlock", 8'(CH_LOCK), 8'h0);
                check("rp_lock", 8'(LOCK), 8'h0);
                check("rp_ready", 8'(CFG_READY), 8'h0);
        go(89); check("rp_ready_up", 8'(CFG_READY), 8'h1);
        go(91); check("rp_ce_c91", 8'(CE), 8'h7);
        go(92); check("rp_y_c92", 8'(Y), 8'h7);
        go(94); check("rp_y_c94", 8'(Y), 8'h0);
        go(95); check("rp_ce_c95", 8'(CE), 8'h7);
        go(103); check("rp_chlock_c103", 8'(CH_LOCK), 8'h0);
        go(104); check("rp_chlock_c104", 8'(CH_LOCK), 8'h7);
        go(105); check("rp_glock_c105", 8'(LOCK), 8'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
